mem_req_master: RTL
===================

Name: mem_req_master

Overview:
- CPU-side initiator for the unified memory wrapper: accepts one load/store at a time from the core's load/store unit.
- Drives the wrapper's mem_sel/mem_read/mem_write request interface and honours its waitrequest handshake.
- Handles the two completion styles behind the wrapper: fixed 1-cycle on-chip RAM read latency, and variable SDRAM latency via readdatavalid.
- Returns a single-pulse response to the core, with a timeout so a lost SDRAM beat cannot hang the pipeline.

Parameters:
- SDRAM_BASE, 32'hC0000000, addresses >= this are routed as SDRAM accesses.
- TIMEOUT, 1024, max cycles waiting for SDRAM command accept or read data before error response.
- STALE_W, 2, width of the counter of abandoned (timed-out) SDRAM reads still owed a beat.

Ports:
- clk  in  1  system clock.
- resetn  in  1  asynchronous active-low reset.
- req_valid  in  1  core request present.
- req_ready  out  1  block can accept; high only in IDLE with vpu_active low.
- req_write  in  1  1=store, 0=load.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data.
- req_wstrb  in  4  store byte enables.
- resp_valid  out  1  one-cycle completion pulse (loads and stores).
- resp_rdata  out  32  load data, valid with resp_valid.
- resp_err  out  1  timeout flag, valid with resp_valid.
- vpu_active  in  1  vector unit owns on-chip RAM; blocks new acceptance.
- mem_sel  out  1  request select to wrapper.
- mem_addr  out  32  word-aligned address (req_addr with [1:0] forced 0).
- mem_wdata  out  32  write data.
- mem_wstrb  out  4  byte enables.
- mem_read  out  1  read command.
- mem_write  out  1  write command.
- mem_rdata  in  32  wrapper read data.
- mem_waitrequest  in  1  wrapper stall.
- sdram_selected  in  1  wrapper routing indication (checked by assertion only).
- sdram_readdatavalid  in  1  SDRAM read beat valid.

Behaviour:
- Reset, asynchronous: state IDLE; all outputs 0; timeout counter and stale counter 0; req_ready 0 while resetn low.
- Accept: on a clk edge with req_valid && req_ready, register write, address, data, strobe and is_sdram = (req_addr >= SDRAM_BASE). Go to ISSUE.
- ISSUE: assert mem_sel, and mem_read or mem_write, from the registered request; the timeout counter runs when is_sdram.
  - On-chip (!is_sdram): waitrequest is always 0. A write goes to RESP next cycle. A read goes to RAM_RD.
  - SDRAM: hold all mem_* stable while mem_waitrequest=1. On the first edge with mem_waitrequest=0, the command is accepted. A write goes to RESP. A read drops mem_read, keeps mem_sel and mem_addr held (the wrapper's read mux depends on them), and goes to SD_DATA.
- RAM_RD: mem_sel and mem_addr held, mem_read=0. Capture mem_rdata at the end of the cycle and go to RESP. Total load latency: accept edge T0, resp_valid in cycle T0+3. Store: resp_valid in T0+2.
- SD_DATA: wait for sdram_readdatavalid.
  - If stale_cnt>0, the beat decrements stale_cnt and is discarded.
  - Otherwise capture mem_rdata and go to RESP.
- RESP: resp_valid=1 for exactly one cycle; mem_* all 0. resp_rdata holds the captured value (0 for stores) until the next RESP. Return to IDLE.
- Timeout: counter clears on accept and counts every cycle in ISSUE(SDRAM) and SD_DATA. When it reaches TIMEOUT-1 without completion:
  - go to RESP with resp_err=1 and resp_rdata=0, deasserting all mem_* in RESP.
  - If the timed-out operation was a read whose command had been accepted, stale_cnt increments.
- stale_cnt saturates at 2^STALE_W-1. sdram_readdatavalid outside SD_DATA decrements stale_cnt if it is nonzero; otherwise the beat is ignored.
- vpu_active: gates acceptance only. An in-flight transaction completes unaffected. vpu_active rising during RAM_RD does not corrupt capture, because RAM output is registered from the ISSUE-cycle address.
- No response backpressure: the core must sink resp_valid.
- Back-to-back: the earliest next acceptance is the cycle after RESP.
- Assertion: in ISSUE, sdram_selected == is_sdram.

Test Plan:
- On-chip store 0x0000_0010, data 0xDEADBEEF, wstrb 4'hF -> one ISSUE cycle with mem_write=1, mem_addr=0x10; resp_valid at T0+2, resp_err=0.
- On-chip load 0x0000_0010 after that store -> mem_read for one cycle, mem_addr held through RAM_RD; resp_rdata=0xDEADBEEF at T0+3.
- SDRAM load 0xC000_0100, waitrequest high 5 cycles, readdatavalid 7 cycles after accept with 0x12345678 -> mem_read held exactly 6 cycles, mem_sel held to the data beat, resp_rdata=0x12345678.
- SDRAM load with no readdatavalid, TIMEOUT=16 -> resp_valid with resp_err=1, rdata=0 at cycle 16, stale_cnt=1. Then a second SDRAM load gets beats 0xAAAA0000 then 0x5555FFFF -> first beat discarded, resp_rdata=0x5555FFFF.
- vpu_active=1 with req_valid=1 -> req_ready=0 and no mem_* activity. When vpu_active drops, the request is accepted on the next edge.
- resetn asserted low mid-SD_DATA -> all outputs 0 immediately, state IDLE, stale_cnt=0. After release, a load at address 0x4 completes normally.

Source files
------------

// File: rtl/mem_req_master.sv
// Single-outstanding load/store initiator for the unified memory wrapper.
// Covers on-chip fixed-latency reads, SDRAM reads via readdatavalid, and a completion timeout.
module mem_req_master #(
  parameter logic [31:0] SDRAM_BASE = 32'hC000_0000,
  parameter int          TIMEOUT    = 1024,
  parameter int          STALE_W    = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  input  logic        vpu_active,
  output logic        mem_sel,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] mem_rdata,
  input  logic        mem_waitrequest,
  input  logic        sdram_selected,
  input  logic        sdram_readdatavalid
);

  localparam int                 TO_W      = $clog2(TIMEOUT) + 1;
  localparam logic [TO_W-1:0]    TO_LAST   = TO_W'(TIMEOUT - 2);
  localparam logic [STALE_W-1:0] STALE_MAX = '1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_RAM_RD,
    ST_SD_DATA,
    ST_RESP
  } state_t;

  state_t             state_reg, state_next;
  logic               write_reg;
  logic               is_sdram_reg;
  logic [31:0]        addr_reg;
  logic [31:0]        wdata_reg;
  logic [3:0]         wstrb_reg;
  logic [TO_W-1:0]    to_cnt_reg, to_cnt_next;
  logic [STALE_W-1:0] stale_cnt_reg, stale_cnt_next;
  logic [31:0]        rdata_reg, rdata_next;
  logic               err_reg, err_next;
  logic               accept;
  logic               to_hit;
  logic               stale_inc;
  logic               stale_dec;

  assign req_ready  = resetn && (state_reg == ST_IDLE) && !vpu_active;
  assign accept     = req_valid && req_ready;
  // Counter lands on TIMEOUT-1 at the edge that abandons the operation.
  assign to_hit     = (to_cnt_reg >= TO_LAST);
  assign stale_dec  = sdram_readdatavalid && (stale_cnt_reg != '0);
  assign resp_rdata = rdata_reg;
  assign resp_err   = err_reg;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg     <= ST_IDLE;
      write_reg     <= 1'b0;
      is_sdram_reg  <= 1'b0;
      addr_reg      <= '0;
      wdata_reg     <= '0;
      wstrb_reg     <= '0;
      to_cnt_reg    <= '0;
      stale_cnt_reg <= '0;
      rdata_reg     <= '0;
      err_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      to_cnt_reg    <= to_cnt_next;
      stale_cnt_reg <= stale_cnt_next;
      rdata_reg     <= rdata_next;
      err_reg       <= err_next;
      if (accept) begin
        write_reg    <= req_write;
        is_sdram_reg <= (req_addr >= SDRAM_BASE);
        addr_reg     <= {req_addr[31:2], 2'b00};
        wdata_reg    <= req_wdata;
        wstrb_reg    <= req_wstrb;
      end
    end
  end

  always_comb begin
    state_next  = state_reg;
    to_cnt_next = to_cnt_reg;
    rdata_next  = rdata_reg;
    err_next    = err_reg;
    stale_inc   = 1'b0;
    mem_sel     = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    mem_wstrb   = '0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    resp_valid  = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          state_next  = ST_ISSUE;
          to_cnt_next = '0;
        end
      end

      ST_ISSUE: begin
        mem_sel   = 1'b1;
        mem_addr  = addr_reg;
        mem_wdata = wdata_reg;
        mem_wstrb = wstrb_reg;
        mem_read  = !write_reg;
        mem_write = write_reg;
        if (!is_sdram_reg) begin
          if (write_reg) begin
            state_next = ST_RESP;
            rdata_next = '0;
            err_next   = 1'b0;
          end else begin
            state_next = ST_RAM_RD;
          end
        end else begin
          to_cnt_next = to_cnt_reg + TO_W'(1);
          if (!mem_waitrequest) begin
            if (write_reg) begin
              state_next = ST_RESP;
              rdata_next = '0;
              err_next   = 1'b0;
            end else begin
              state_next = ST_SD_DATA;
            end
          end else if (to_hit) begin
            state_next = ST_RESP;
            rdata_next = '0;
            err_next   = 1'b1;
          end
        end
      end

      ST_RAM_RD: begin
        // Select and address stay up because the wrapper read mux follows them.
        mem_sel    = 1'b1;
        mem_addr   = addr_reg;
        rdata_next = mem_rdata;
        err_next   = 1'b0;
        state_next = ST_RESP;
      end

      ST_SD_DATA: begin
        mem_sel     = 1'b1;
        mem_addr    = addr_reg;
        to_cnt_next = to_cnt_reg + TO_W'(1);
        if (sdram_readdatavalid && (stale_cnt_reg == '0)) begin
          rdata_next = mem_rdata;
          err_next   = 1'b0;
          state_next = ST_RESP;
        end else if (to_hit) begin
          rdata_next = '0;
          err_next   = 1'b1;
          stale_inc  = 1'b1;
          state_next = ST_RESP;
        end
      end

      ST_RESP: begin
        resp_valid = 1'b1;
        state_next = ST_IDLE;
      end

      default: state_next = ST_IDLE;
    endcase
  end

  // Beats owed to abandoned reads are swallowed wherever they show up.
  always_comb begin
    stale_cnt_next = stale_cnt_reg;
    if (stale_dec && !stale_inc)
      stale_cnt_next = stale_cnt_reg - STALE_W'(1);
    else if (stale_inc && !stale_dec && (stale_cnt_reg != STALE_MAX))
      stale_cnt_next = stale_cnt_reg + STALE_W'(1);
  end

  a_route: assert property (@(posedge clk) disable iff (!resetn)
    (state_reg == ST_ISSUE) |-> (sdram_selected == is_sdram_reg));

endmodule
